hilo_unit: RTL and testbench

- Owns the architectural HI/LO register pair for the MIPS datapath.
- It is the other end of the ALU's HI/LO interface:
  - supplies the concatenated HiLo that the ALU reads for MFHI/MFLO/MADD/MSUB;
  - captures the ALU's 64-bit product result.
- Adds MTHI/MTLO and an iterative signed/unsigned DIV/DIVU engine with a busy/done handshake the hazard unit uses to stall.

---
 rtl/hilo_pkg.sv | 51 +++++
 rtl/div_core.sv | 137 +++++++++++++
 rtl/hilo_unit.sv | 102 ++++++++++
 tb/tb_hilo_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: op codes, divider state encoding, decode helper.
package hilo_pkg;

    localparam int unsigned HILO_WIDTH      = 32;
    localparam int unsigned HILO_DIV_CYCLES = 32;
    localparam int unsigned OP_W            = 3;

    localparam logic [OP_W-1:0] HILO_NOP  = 3'd0;
    localparam logic [OP_W-1:0] HILO_WR64 = 3'd1;
    localparam logic [OP_W-1:0] HILO_MTHI = 3'd2;
    localparam logic [OP_W-1:0] HILO_MTLO = 3'd3;
    localparam logic [OP_W-1:0] HILO_DIV  = 3'd4;
    localparam logic [OP_W-1:0] HILO_DIVU = 3'd5;
    localparam logic [OP_W-1:0] HILO_CLR  = 3'd6;
    localparam logic [OP_W-1:0] HILO_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    typedef struct packed {
        logic wr64;
        logic mthi;
        logic mtlo;
        logic clr;
        logic div_start;
        logic div_signed;
    } op_dec_t;

    // One-hot style decode; NOP and the reserved code map to no action.
    function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
        op_dec_t d;
        d = '0;
        case (op)
            HILO_WR64: d.wr64 = 1'b1;
            HILO_MTHI: d.mthi = 1'b1;
            HILO_MTLO: d.mtlo = 1'b1;
            HILO_DIV: begin
                d.div_start  = 1'b1;
                d.div_signed = 1'b1;
            end
            HILO_DIVU: d.div_start = 1'b1;
            HILO_CLR:  d.clr = 1'b1;
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider, one quotient bit per cycle, with signed magnitude
// conversion on entry and sign correction in a final fix-up cycle.
module div_core
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH      = HILO_WIDTH,
    parameter int unsigned DIV_CYCLES = HILO_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             res_wr_c,
    output logic [WIDTH-1:0] quo_c,
    output logic [WIDTH-1:0] rem_c,
    output logic             by_zero
);

    localparam int unsigned        CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             load_c;
    logic             iter_c;
    logic             fix_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;

    // Magnitude in WIDTH+1 bits so the most negative value converts without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        logic [WIDTH:0] ext;
        ext = {sgn & x[WIDTH-1], x};
        if (ext[WIDTH]) begin
            ext = -ext;
        end
        return ext[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_ITER) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_c = 1'b0;
        iter_c = 1'b0;
        fix_c  = 1'b0;
        case (state_q)
            ST_IDLE: load_c = start;
            ST_RUN:  iter_c = 1'b1;
            ST_FIX:  fix_c  = 1'b1;
            default: ;
        endcase
    end

    // Trial subtraction: a borrow out of the top bit means the divisor did not fit.
    always_comb begin
        shifted_c = {rem_q, quo_q[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            by_zero   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= fix_c;
            if (load_c) begin
                cnt_q     <= '0;
                rem_q     <= '0;
                quo_q     <= magnitude(dividend, is_signed);
                dvs_q     <= magnitude(divisor, is_signed);
                dvd_q     <= dividend;
                neg_quo_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_rem_q <= is_signed & dividend[WIDTH-1];
                by_zero   <= (divisor == '0);
            end else if (iter_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!diff_c[WIDTH]) begin
                    rem_q <= diff_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Sign fix-up; a zero divisor returns the dividend as remainder and all-ones quotient.
    always_comb begin
        res_wr_c = fix_c;
        if (by_zero) begin
            quo_c = '1;
            rem_c = dvd_q;
        end else begin
            quo_c = neg_quo_q ? -quo_q : quo_q;
            rem_c = neg_rem_q ? -rem_q : rem_q;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair with MTHI/MTLO/WR64/CLR and an iterative divider.
// Optional same-cycle write forwarding onto hilo is enabled by defining HILO_BYPASS_EN.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH      = HILO_WIDTH,
    parameter int unsigned DIV_CYCLES = HILO_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] alu64_result,
    output logic [2*WIDTH-1:0] hilo,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_new_c;
    logic [WIDTH-1:0] lo_new_c;

    logic             accept_c;
    op_dec_t          dec_c;
    logic             div_start_c;
    logic             div_wr_c;
    logic [WIDTH-1:0] div_quo_c;
    logic [WIDTH-1:0] div_rem_c;
    logic             div_by_zero;

    // Ops arriving while the divider is busy are dropped; the hazard unit holds them.
    always_comb begin
        accept_c    = op_valid & ~busy;
        dec_c       = decode_op(op);
        div_start_c = accept_c & dec_c.div_start;
    end

    always_comb begin
        hi_new_c = hi_q;
        lo_new_c = lo_q;
        if (accept_c) begin
            if (dec_c.wr64) begin
                hi_new_c = alu64_result[2*WIDTH-1:WIDTH];
                lo_new_c = alu64_result[WIDTH-1:0];
            end
            if (dec_c.mthi) hi_new_c = a;
            if (dec_c.mtlo) lo_new_c = a;
            if (dec_c.clr) begin
                hi_new_c = '0;
                lo_new_c = '0;
            end
        end
    end

    div_core #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_c),
        .is_signed (dec_c.div_signed),
        .dividend  (a),
        .divisor   (b),
        .busy      (busy),
        .done      (done),
        .res_wr_c  (div_wr_c),
        .quo_c     (div_quo_c),
        .rem_c     (div_rem_c),
        .by_zero   (div_by_zero)
    );

    // Divider writeback only happens while busy, so it never collides with an accepted op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            div_zero <= 1'b0;
        end else if (div_wr_c) begin
            hi_q     <= div_rem_c;
            lo_q     <= div_quo_c;
            div_zero <= div_by_zero;
        end else begin
            hi_q <= hi_new_c;
            lo_q <= lo_new_c;
            if (accept_c & dec_c.clr) begin
                div_zero <= 1'b0;
            end
        end
    end

`ifdef HILO_BYPASS_EN
    assign hilo = {hi_new_c, lo_new_c};
`else
    assign hilo = {hi_q, lo_q};
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized self-checking bench for hilo_unit against an arithmetic reference model.
module tb_hilo_unit;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = 33;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_WR64 = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_DIVU = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           op_valid;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] alu64_result;
    logic [2*W-1:0] hilo;
    logic           busy;
    logic           done;
    logic           div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dz;

    always #5 clk = ~clk;

    hilo_unit #(.WIDTH(W), .DIV_CYCLES(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op           (op),
        .a            (a),
        .b            (b),
        .alu64_result (alu64_result),
        .hilo         (hilo),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference divide straight from the architectural rules.
    task automatic model_div(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        sx = x;
        sy = y;
        dz = 1'b0;
        if (y == 0) begin
            q  = '1;
            r  = x;
            dz = 1'b1;
        end else if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                q = sx / sy;
                r = sx % sy;
            end
        end else begin
            q = x / y;
            r = x % y;
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [63:0] vr, input bit junk);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        bit           is_div;
        eh = m_hi;
        el = m_lo;
        edz = m_dz;
        is_div = (o == OP_DIV) || (o == OP_DIVU);
        case (o)
            OP_WR64: begin eh = vr[63:32]; el = vr[31:0]; end
            OP_MTHI: eh = va;
            OP_MTLO: el = va;
            OP_CLR:  begin eh = '0; el = '0; edz = 1'b0; end
            OP_DIV, OP_DIVU: model_div(o == OP_DIV, va, vb, el, eh, edz);
            default: ;
        endcase
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        alu64_result = vr;
`ifdef HILO_BYPASS_EN
        if (o inside {OP_WR64, OP_MTHI, OP_MTLO, OP_CLR}) check("bypass_hilo", hilo, {eh, el});
        else check("no_bypass_hilo", hilo, {m_hi, m_lo});
`endif
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (!is_div) begin
            check("hilo", hilo, {eh, el});
            check("busy", 64'(busy), 64'd0);
            check("done", 64'(done), 64'd0);
            check("div_zero", 64'(div_zero), 64'(edz));
        end else begin
            for (int k = 0; k < LAT; k++) begin
                check("busy_run", 64'(busy), 64'd1);
                check("done_run", 64'(done), 64'd0);
                check("hilo_hold", hilo, {m_hi, m_lo});
                check("dz_hold", 64'(div_zero), 64'(m_dz));
                if (junk) begin
                    op_valid = 1'b1;
                    op = 3'($urandom_range(0, 7));
                    a = $urandom;
                    b = $urandom;
                    alu64_result = '1;
                end
                @(posedge clk);
                #1;
            end
            op_valid = 1'b0;
            check("busy_end", 64'(busy), 64'd0);
            check("done_pulse", 64'(done), 64'd1);
            check("div_hilo", hilo, {eh, el});
            check("div_zero", 64'(div_zero), 64'(edz));
            @(posedge clk);
            #1;
            check("done_single", 64'(done), 64'd0);
        end
        m_hi = eh;
        m_lo = el;
        m_dz = edz;
    endtask

    task automatic mid_reset();
        run_op(OP_WR64, '0, '0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_DIV;
        a = 32'h1234_5678;
        b = 32'h0000_0003;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_hilo", hilo, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_done", 64'(done), 64'd0);
        end
        check("rst_hilo_after", hilo, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        op_valid = 1'b0;
        op = OP_NOP;
        a = '0;
        b = '0;
        alu64_result = '0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", hilo, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_WR64, '0, '0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        check("wr64_literal", hilo, 64'h1234_5678_9ABC_DEF0);
        run_op(OP_MTHI, 32'hDEAD_BEEF, '0, '0, 1'b0);
        run_op(OP_MTLO, 32'h0000_0005, '0, '0, 1'b0);
        check("mthi_mtlo_literal", hilo, 64'hDEAD_BEEF_0000_0005);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, 1'b0);
        check("div_m7_2_literal", hilo, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIVU, 32'd100, 32'd7, '0, 1'b0);
        check("divu_100_7_literal", hilo, 64'h0000_0002_0000_000E);
        run_op(OP_DIVU, 32'h0000_ABCD, 32'd0, '0, 1'b0);
        check("divzero_literal", hilo, 64'h0000_ABCD_FFFF_FFFF);
        check("divzero_flag", 64'(div_zero), 64'd1);
        run_op(OP_CLR, '0, '0, '0, 1'b0);
        check("clr_flag", 64'(div_zero), 64'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b1);
        check("div_wrap_literal", hilo, 64'h0000_0000_8000_0000);
        run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, '0, 1'b1);

        mid_reset();

        for (int i = 0; i < 250; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   {$urandom, $urandom}, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
